// File: rtl/program_loader.sv
// program_loader: receives a 16-byte image from a host, optionally verifies
// a trailing checksum byte, then feeds each word to the control block through
// its programming handshake (read_ui_in at T3, done_load at T4).
// Optional feature macro: LOADER_CHECKSUM_EN (adds a 17th checksum byte).
module program_loader (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       host_valid,
  input  logic [7:0] host_data,
  output logic       host_ready,
  output logic       programming,
  input  logic       read_ui_in,
  input  logic       done_load,
  output logic [7:0] load_data,
  output logic [3:0] load_idx,
  output logic       load_done,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    CHECK = 3'd2,
    PROG  = 3'd3,
    DONE  = 3'd4
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam logic [4:0] LAST_CNT = 5'd16;
`else
  localparam logic [4:0] LAST_CNT = 5'd15;
`endif

  state_t     state_q, state_d;
  logic [4:0] rx_cnt_q, rx_cnt_d;
  logic [3:0] load_idx_q, load_idx_d;
  logic       load_done_q, load_done_d;
  logic       error_q, error_d;
  logic       programming_q, programming_d;
  logic       read_seen_q, read_seen_d;
  logic [7:0] img_q [16];
  logic [7:0] img_d [16];
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  logic xfer;

  assign host_ready  = (state_q == RECV);
  assign xfer        = host_ready && host_valid;
  assign programming = programming_q;
  assign load_idx    = load_idx_q;
  assign load_done   = load_done_q;
  assign error       = error_q;
  assign load_data   = (state_q == PROG) ? img_q[load_idx_q] : 8'h00;

  // Next-state logic: receive bytes, check, then step words through the control block
  always_comb begin
    state_d       = state_q;
    rx_cnt_d      = rx_cnt_q;
    load_idx_d    = load_idx_q;
    load_done_d   = load_done_q;
    error_d       = error_q;
    programming_d = programming_q;
    read_seen_d   = read_seen_q;
    img_d         = img_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d         = sum_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RECV;
          rx_cnt_d    = 5'd0;
          load_idx_d  = 4'd0;
          load_done_d = 1'b0;
          error_d     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          sum_d       = 8'h00;
`endif
        end
      end
      RECV: begin
        if (xfer) begin
          // The checksum byte (count 16) is only summed, never stored
          if (!rx_cnt_q[4]) begin
            img_d[rx_cnt_q[3:0]] = host_data;
          end
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + host_data;
`endif
          rx_cnt_d = rx_cnt_q + 5'd1;
          if (rx_cnt_q == LAST_CNT) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (sum_q != 8'h00) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else begin
          state_d       = PROG;
          programming_d = 1'b1;
          read_seen_d   = 1'b0;
        end
`else
        state_d       = PROG;
        programming_d = 1'b1;
        read_seen_d   = 1'b0;
`endif
      end
      PROG: begin
        read_seen_d = read_seen_q | read_ui_in;
        if (done_load) begin
          // A commit with no read since the last commit is a protocol fault
          if (!(read_seen_q || read_ui_in)) begin
            error_d = 1'b1;
          end
          read_seen_d = 1'b0;
          load_idx_d  = load_idx_q + 4'd1;
          if (load_idx_q == 4'd15) begin
            state_d       = DONE;
            programming_d = 1'b0;
            load_done_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d       = IDLE;
        programming_d = 1'b0;
      end
    endcase
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      rx_cnt_q      <= 5'd0;
      load_idx_q    <= 4'd0;
      load_done_q   <= 1'b0;
      error_q       <= 1'b0;
      programming_q <= 1'b0;
      read_seen_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q         <= 8'h00;
`endif
    end else begin
      state_q       <= state_d;
      rx_cnt_q      <= rx_cnt_d;
      load_idx_q    <= load_idx_d;
      load_done_q   <= load_done_d;
      error_q       <= error_d;
      programming_q <= programming_d;
      read_seen_q   <= read_seen_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q         <= sum_d;
`endif
    end
  end

  // Image buffer has no reset; its contents are only meaningful after a full receive
  always_ff @(posedge clk) begin
    img_q <= img_d;
  end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed stimulus, a behavioural model that
// tracks the expected outputs every cycle, and literal spot checks.
// Define LOADER_CHECKSUM_EN to also exercise the checksum build.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       resetn, start, host_valid, read_ui_in, done_load;
  logic [7:0] host_data;
  logic       host_ready, programming, load_done, error;
  logic [7:0] load_data;
  logic [3:0] load_idx;

  int n_checks = 0;
  int n_errors = 0;

`ifdef LOADER_CHECKSUM_EN
  localparam int NBYTES = 17;
  localparam bit CKS    = 1'b1;
`else
  localparam int NBYTES = 16;
  localparam bit CKS    = 1'b0;
`endif

  logic [7:0] tx_img [16];

  program_loader dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .host_valid  (host_valid),
    .host_data   (host_data),
    .host_ready  (host_ready),
    .programming (programming),
    .read_ui_in  (read_ui_in),
    .done_load   (done_load),
    .load_data   (load_data),
    .load_idx    (load_idx),
    .load_done   (load_done),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase of the load, bytes received, expected image and flags
  typedef enum int { P_IDLE, P_RECV, P_CHECK, P_PROG, P_DONE } phase_t;
  phase_t     m_phase;
  int         m_cnt, m_idx, m_sum;
  bit         m_done, m_err, m_seen, m_valid = 1'b0;
  logic [7:0] m_img [16];

  always @(posedge clk) begin
    if (!resetn) begin
      m_phase = P_IDLE; m_cnt = 0; m_idx = 0; m_done = 0; m_err = 0; m_seen = 0; m_sum = 0;
      m_valid = 1'b1;
    end else begin
      case (m_phase)
        P_IDLE, P_DONE: if (start) begin
          m_phase = P_RECV; m_cnt = 0; m_idx = 0; m_done = 0; m_err = 0; m_sum = 0;
        end
        P_RECV: if (host_valid) begin
          if (m_cnt < 16) m_img[m_cnt] = host_data;
          m_sum = m_sum + int'(host_data);
          m_cnt++;
          if (m_cnt == NBYTES) m_phase = P_CHECK;
        end
        P_CHECK: begin
          if (CKS && (m_sum % 256) != 0) begin
            m_phase = P_IDLE; m_err = 1;
          end else begin
            m_phase = P_PROG; m_seen = 0;
          end
        end
        P_PROG: begin
          if (done_load) begin
            if (!(m_seen || read_ui_in)) m_err = 1;
            m_seen = 0;
            m_idx++;
            if (m_idx == 16) begin
              m_idx = 0; m_phase = P_DONE; m_done = 1;
            end
          end else if (read_ui_in) begin
            m_seen = 1;
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (m_valid) begin
      check_output("m_host_ready", {7'd0, host_ready}, {7'd0, m_phase == P_RECV});
      check_output("m_programming", {7'd0, programming}, {7'd0, m_phase == P_PROG});
      check_output("m_load_data", load_data, (m_phase == P_PROG) ? m_img[m_idx] : 8'h00);
      check_output("m_load_idx", {4'd0, load_idx}, 8'(m_idx));
      check_output("m_load_done", {7'd0, load_done}, {7'd0, m_done});
      check_output("m_error", {7'd0, error}, {7'd0, m_err});
    end
  end

  function automatic logic [7:0] good_cks();
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 16; i++) s = s + tx_img[i];
    return 8'h00 - s;
  endfunction

  // Pulse start, stream the image (optional stall after 7 bytes), check entry into PROG
  task automatic apply_stimulus(input int stall_len, input logic [7:0] cks, input bit expect_prog);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("start_host_ready", {7'd0, host_ready}, 8'd1);
    check_output("start_error", {7'd0, error}, 8'd0);
    check_output("start_load_done", {7'd0, load_done}, 8'd0);
    for (int i = 0; i < NBYTES; i++) begin
      if (i == 7 && stall_len > 0) begin
        host_valid = 1'b0;
        host_data  = 8'hEE;
        start      = 1'b1;
        repeat (stall_len) begin
          @(negedge clk);
          check_output("stall_host_ready", {7'd0, host_ready}, 8'd1);
        end
        start = 1'b0;
      end
      host_valid = 1'b1;
      host_data  = (i < 16) ? tx_img[i] : cks;
      @(negedge clk);
    end
    host_valid = 1'b0;
    host_data  = 8'h00;
    check_output("last_host_ready", {7'd0, host_ready}, 8'd0);
    check_output("check_programming", {7'd0, programming}, 8'd0);
    @(negedge clk);
    if (expect_prog) begin
      check_output("prog_entry", {7'd0, programming}, 8'd1);
      check_output("prog_first_data", load_data, tx_img[0]);
    end else begin
      repeat (4) begin
        check_output("bad_cks_programming", {7'd0, programming}, 8'd0);
        check_output("bad_cks_error", {7'd0, error}, 8'd1);
        check_output("bad_cks_host_ready", {7'd0, host_ready}, 8'd0);
        @(negedge clk);
      end
    end
  endtask

  // Drive read/commit pairs for n words; optional missing read and same-edge read+commit
  task automatic program_words(input int n_words, input int fault_at, input int same_edge_at);
    for (int i = 0; i < n_words; i++) begin
      check_output("word_idx", {4'd0, load_idx}, 8'(i));
      check_output("word_data", load_data, tx_img[i]);
      if (i == same_edge_at) begin
        read_ui_in = 1'b1;
        done_load  = 1'b1;
        @(negedge clk);
        read_ui_in = 1'b0;
        done_load  = 1'b0;
      end else begin
        read_ui_in = (i != fault_at);
        @(negedge clk);
        read_ui_in = 1'b0;
        @(negedge clk);
        check_output("word_data_stable", load_data, tx_img[i]);
        done_load = 1'b1;
        @(negedge clk);
        done_load = 1'b0;
      end
      if (i == fault_at) begin
        check_output("fault_error", {7'd0, error}, 8'd1);
        check_output("fault_idx", {4'd0, load_idx}, 8'(i + 1));
        check_output("fault_programming", {7'd0, programming}, 8'd1);
      end
    end
    if (n_words == 16) begin
      check_output("end_load_done", {7'd0, load_done}, 8'd1);
      check_output("end_programming", {7'd0, programming}, 8'd0);
      check_output("end_load_data", load_data, 8'h00);
      check_output("end_load_idx", {4'd0, load_idx}, 8'd0);
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; host_valid = 1'b0; host_data = 8'h00;
    read_ui_in = 1'b0; done_load = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_host_ready", {7'd0, host_ready}, 8'd0);
    check_output("rst_programming", {7'd0, programming}, 8'd0);
    check_output("rst_load_data", load_data, 8'h00);
    check_output("rst_load_idx", {4'd0, load_idx}, 8'd0);
    check_output("rst_load_done", {7'd0, load_done}, 8'd0);
    check_output("rst_error", {7'd0, error}, 8'd0);
    resetn = 1'b1;
    @(negedge clk);

    $display("[TB] basic image 10..1F");
    for (int i = 0; i < 16; i++) tx_img[i] = 8'h10 + 8'(i);
    apply_stimulus(0, good_cks(), 1'b1);
    check_output("basic_first_word", load_data, 8'h10);
    program_words(16, -1, 5);
    check_output("basic_no_error", {7'd0, error}, 8'd0);

    $display("[TB] stalled receive");
    for (int i = 0; i < 16; i++) tx_img[i] = 8'hA5 ^ 8'(i * 29);
    apply_stimulus(5, good_cks(), 1'b1);
    program_words(16, -1, -1);

    $display("[TB] protocol fault at word 3");
    for (int i = 0; i < 16; i++) tx_img[i] = 8'hF0 - 8'(i * 3);
    apply_stimulus(0, good_cks(), 1'b1);
    program_words(16, 3, -1);
    check_output("fault_sticky", {7'd0, error}, 8'd1);

    $display("[TB] reset mid-programming");
    for (int i = 0; i < 16; i++) tx_img[i] = 8'h3C + 8'(i * 17);
    apply_stimulus(0, good_cks(), 1'b1);
    program_words(9, -1, -1);
    check_output("pre_rst_idx", {4'd0, load_idx}, 8'd9);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check_output("mid_rst_programming", {7'd0, programming}, 8'd0);
    check_output("mid_rst_idx", {4'd0, load_idx}, 8'd0);
    check_output("mid_rst_host_ready", {7'd0, host_ready}, 8'd0);
    @(negedge clk);
    for (int i = 0; i < 16; i++) tx_img[i] = 8'h81 + 8'(i * 5);
    apply_stimulus(0, good_cks(), 1'b1);
    program_words(16, -1, -1);

`ifdef LOADER_CHECKSUM_EN
    $display("[TB] checksum good and bad");
    for (int i = 0; i < 16; i++) tx_img[i] = 8'h01;
    apply_stimulus(0, 8'hF0, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    apply_stimulus(0, 8'hF1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port resetn  input  1  reset; synchronous, active-low.
REQ-003 SHALL have port start  input  1  level-sampled request to begin a new image load.
REQ-004 SHALL have port host_valid  input  1  host byte available.
REQ-005 SHALL have port host_data  input  8  host byte: opcode in [7:4], operand in [3:0].
REQ-006 SHALL have port host_ready  output  1  loader accepts a host byte this cycle.
REQ-007 SHALL have port programming  output  1  drives control-block programming mode.
REQ-008 SHALL have port read_ui_in  input  1  control block sampling the load bus (T3 of programming cycle).
REQ-009 SHALL have port done_load  input  1  control block committed the word to RAM (T4).
REQ-010 SHALL have port load_data  output  8  word presented to the CPU input bus.
REQ-011 SHALL have port load_idx  output  4  index of the word currently presented.
REQ-012 SHALL have port load_done  output  1  image fully written; held until next start or reset.
REQ-013 SHALL have port error  output  1  sticky fault flag: checksum mismatch or protocol fault.

Function
REQ-014 SHALL implement states IDLE, RECV, CHECK, PROG and DONE.
REQ-015 SHALL hold a 16 x 8 image buffer and a 5-bit receive counter rx_cnt.
REQ-016 SHALL move IDLE or DONE -> RECV on start=1 and clear rx_cnt, load_idx, load_done and error in that cycle.
REQ-017 SHALL ignore start in RECV, CHECK and PROG.
REQ-018 SHALL drive host_ready=1 only in RECV; a byte transfers on a rising edge with host_valid=1 and host_ready=1.
REQ-019 SHALL write bytes 0..15 to buf[rx_cnt] and increment rx_cnt per transfer; host_valid=0 stalls without penalty.
REQ-020 SHALL move RECV -> CHECK on the edge that accepts the final byte; host_ready is 0 in the following cycle.
REQ-021 SHALL spend exactly one cycle in CHECK, then go to PROG, or to IDLE with error=1 per REQ-033.
REQ-022 SHALL hold programming=1 throughout PROG only; it is registered with no combinational path from inputs.
REQ-023 SHALL drive load_data = buf[load_idx] in PROG and 8'h00 in every other state.
REQ-024 SHALL keep load_data stable from the first PROG cycle until the edge that samples done_load=1.
REQ-025 SHALL increment load_idx on each rising edge in PROG that samples done_load=1.
REQ-026 SHALL, on done_load=1 with load_idx=15, go to DONE, clear programming, set load_done=1 and wrap load_idx to 0, all on that edge.
REQ-027 SHALL set error=1 and stay in PROG if done_load=1 arrives without a read_ui_in=1 since the previous commit (protocol fault); the word still advances.
REQ-028 SHALL ignore read_ui_in and done_load outside PROG.
REQ-029 SHALL treat read_ui_in=1 and done_load=1 sampled on the same edge as a read followed by a commit, with no fault.

Reset
REQ-030 SHALL, when resetn=0 at a rising edge, enter IDLE with host_ready=0, programming=0, load_data=8'h00, load_idx=0, load_done=0, error=0 and rx_cnt=0.
REQ-031 SHALL abort any load on reset mid-RECV or mid-PROG; buffer contents are not cleared and are don't-care afterwards.

Configuration
REQ-032 SHALL provide macro LOADER_CHECKSUM_EN.
REQ-033 SHALL, with LOADER_CHECKSUM_EN defined, accept 17 bytes in RECV; byte 16 is a checksum, valid when (sum of bytes 0..15 + byte 16) mod 256 = 0; CHECK routes a mismatch to IDLE with error=1 and a match to PROG.
REQ-034 SHALL, without LOADER_CHECKSUM_EN, accept exactly 16 bytes; CHECK always goes to PROG and error is set only by REQ-027.

Verification
REQ-035 SHALL cover: reset, start, 16 bytes 8'h10..8'h1F with host_valid held high -> host_ready low after byte 16, programming=1 two cycles later, load_data=8'h10.
REQ-036 SHALL cover: 16 read_ui_in/done_load pairs -> load_idx steps 0..15, load_data tracks buf, and after the 16th commit load_done=1, programming=0, load_data=8'h00.
REQ-037 SHALL cover: host_valid deasserted for 5 cycles after byte 7 -> rx_cnt holds at 7 and the image is unchanged at completion.
REQ-038 SHALL cover, with LOADER_CHECKSUM_EN: bytes 8'h01 x16 plus 8'hF0 -> PROG entered; plus 8'hF1 instead -> IDLE, error=1, programming never asserted.
REQ-039 SHALL cover: resetn=0 for one cycle at load_idx=9 in PROG -> IDLE, programming=0, load_idx=0; a new start then receives and programs normally.
REQ-040 SHALL cover: done_load=1 without a prior read_ui_in at load_idx=3 -> error=1, load_idx=4, programming remains 1.
